mem_access: RTL and testbench

Data-memory stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It runs loads and stores against an external data memory over a req/ack handshake. It formats byte, halfword and word data, and stalls the upstream pipeline while an access is in flight. During a stall it sends bubbles into MEM/WB, and it reports misaligned accesses and bus timeouts.

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the external data memory.
// The MEM stage drives the request side; the memory answers with rdata/ack.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the 5-stage pipeline. It runs loads and stores over a
// req/ack bus, formats sub-word data, stalls upstream while an access is in
// flight and sends bubbles into MEM/WB during the stall. It also reports
// misaligned accesses and bus timeouts as one-cycle pulses.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead_MEM,
  input  logic                MemWrite_MEM,
  input  logic                MemtoReg_MEM,
  input  logic                RegWrite_MEM,
  input  logic [2:0]          funct3_MEM,
  input  logic [31:0]         alu_in,
  input  logic [31:0]         wdata_in,
  input  logic [4:0]          rd_in,
  mem_access_if.master        dmem,
  output logic                stall_out,
  output logic                MemtoReg_WB,
  output logic                RegWrite_WB,
  output logic [31:0]         data_out,
  output logic [31:0]         alu_out,
  output logic [4:0]          rd_out,
  output logic                misalign_err,
  output logic                bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Access size from funct3; unknown encodings fall back to word.
  function automatic size_t acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return SZ_B;
      3'b001, 3'b101: return SZ_H;
      default:        return SZ_W;
    endcase
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte enables for a store, shifted to the addressed lane.
  function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lane always sees it.
  function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it;
  // funct3[2] selects zero extension (BU/HU).
  function automatic logic [31:0] load_format(input logic [2:0] f3,
                                              input logic [1:0] a,
                                              input logic [31:0] rw);
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    b8  = 8'(rw >> {a, 3'b000});
    h16 = 16'(rw >> {a[1], 4'b0000});
    case (acc_size(f3))
      SZ_B:    return f3[2] ? {24'h0, b8}  : 32'(b8);
      SZ_H:    return f3[2] ? {16'h0, h16} : 32'(h16);
      default: return rw;
    endcase
  endfunction

  state_t      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] ldata_q;
  logic        misalign_q;
  logic        buserr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;

  logic        mem_op;
  logic        is_store;
  size_t       size;
  logic        timeout_hit;

  assign mem_op      = MemRead_MEM | MemWrite_MEM;
  assign is_store    = MemWrite_MEM;
  assign size        = acc_size(funct3_MEM);
  assign cnt_d       = cnt_q + 8'd1;
  assign timeout_hit = (cnt_d == 8'(TIMEOUT));

  // Access FSM: owns every registered bus output, the captured load data and
  // the latched error flags. EX/MEM is frozen while we stall, so alu_in and
  // funct3_MEM are still valid when the ack comes back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      ldata_q    <= 32'h0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      cnt_q      <= 8'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            ldata_q <= 32'h0;
            cnt_q   <= 8'h0;
            if (is_misaligned(size, alu_in[1:0])) begin
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= {alu_in[31:2], 2'b00};
              be_q    <= is_store ? store_be(size, alu_in[1:0]) : 4'b1111;
              wdata_q <= is_store ? store_data(size, wdata_in) : 32'h0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack in the timeout cycle wins over the timeout.
          if (dmem.dmem_ack) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= 8'h0;
            if (!we_q) ldata_q <= load_format(funct3_MEM, alu_in[1:0], dmem.dmem_rdata);
            state_q <= DONE;
          end else if (timeout_hit) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 8'h0;
            buserr_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          misalign_q <= 1'b0;
          buserr_q   <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign alu_out = alu_in;
  assign rd_out  = rd_in;

  // Stall and MEM/WB control: bubble while an access is pending, pass
  // through otherwise, and hold everything quiet while reset is asserted.
  always_comb begin
    stall_out    = 1'b0;
    RegWrite_WB  = 1'b0;
    MemtoReg_WB  = 1'b0;
    data_out     = 32'h0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            stall_out = 1'b1;
          end else begin
            RegWrite_WB = RegWrite_MEM;
            MemtoReg_WB = MemtoReg_MEM;
          end
        end
        BUSY: stall_out = 1'b1;
        DONE: begin
          RegWrite_WB  = RegWrite_MEM & ~(misalign_q | buserr_q);
          MemtoReg_WB  = MemtoReg_MEM;
          data_out     = ldata_q;
          misalign_err = misalign_q;
          bus_err      = buserr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives the pipeline inputs and plays the
// data memory by hand, checking against hand-computed values.
module tb_mem_access;

  logic        clk;
  logic        reset;
  logic        MemRead_MEM, MemWrite_MEM, MemtoReg_MEM, RegWrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] alu_in, wdata_in;
  logic [4:0]  rd_in;
  logic        stall_out, MemtoReg_WB, RegWrite_WB;
  logic [31:0] data_out, alu_out;
  logic [4:0]  rd_out;
  logic        misalign_err, bus_err;

  mem_access_if bus();

  mem_access #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead_MEM  (MemRead_MEM),
    .MemWrite_MEM (MemWrite_MEM),
    .MemtoReg_MEM (MemtoReg_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .funct3_MEM   (funct3_MEM),
    .alu_in       (alu_in),
    .wdata_in     (wdata_in),
    .rd_in        (rd_in),
    .dmem         (bus),
    .stall_out    (stall_out),
    .MemtoReg_WB  (MemtoReg_WB),
    .RegWrite_WB  (RegWrite_WB),
    .data_out     (data_out),
    .alu_out      (alu_out),
    .rd_out       (rd_out),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Snapshot of the bus in the first BUSY cycle and during the ack cycle.
  logic        s_req, s_we, ack_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  int          stall_cnt, req_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rw, input logic m2r, input logic [4:0] rdi);
    MemRead_MEM  = rd;
    MemWrite_MEM = wr;
    funct3_MEM   = f3;
    alu_in       = a;
    wdata_in     = wd;
    RegWrite_MEM = rw;
    MemtoReg_MEM = m2r;
    rd_in        = rdi;
  endtask

  // One cycle with a non-memory op in EX/MEM; returns at a falling edge.
  task automatic nop_cycle();
    set_op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs an already-applied memory op from IDLE until stall_out drops.
  // ack_cycle = BUSY cycle (1-based) that sees the ack; 0 = never.
  // Returns at negedge+1 of the DONE cycle.
  task automatic access(input int ack_cycle, input logic [31:0] rdata);
    int cyc;
    cyc = 0;
    stall_cnt = 0;
    req_cnt = 0;
    s_req = 1'b0; s_we = 1'b0; ack_we = 1'b0;
    s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0;
    #1;
    while (stall_out === 1'b1 && cyc < 40) begin
      stall_cnt++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.dmem_ack   = (cyc == ack_cycle);
      bus.dmem_rdata = (cyc == ack_cycle) ? rdata : 32'hDEAD_BEEF;
      #1;
      if (bus.dmem_req === 1'b1) req_cnt++;
      if (cyc == 1) begin
        s_req = bus.dmem_req; s_we = bus.dmem_we; s_addr = bus.dmem_addr;
        s_be = bus.dmem_be; s_wdata = bus.dmem_wdata;
      end
      if (cyc == ack_cycle) ack_we = bus.dmem_we;
    end
    bus.dmem_ack = 1'b0;
    chk("access_bounded", 32'(cyc < 40), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with a load presented: everything must stay quiet.
    reset = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'h0;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 1'b1, 5'd3);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_WB), 32'd0);
    chk("rst_memtoreg", 32'(MemtoReg_WB), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_be", 32'(bus.dmem_be), 32'h0);

    // Non-memory op: same-cycle passthrough.
    reset = 1'b1;
    set_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 1'b0, 5'd5);
    #1;
    chk("nop_regwrite", 32'(RegWrite_WB), 32'd1);
    chk("nop_rd", 32'(rd_out), 32'd5);
    chk("nop_alu", alu_out, 32'h1234);
    chk("nop_stall", 32'(stall_out), 32'd0);
    chk("nop_data", data_out, 32'h0);

    // LB at 0x103, ack in second BUSY cycle.
    nop_cycle();
    set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1'b1, 5'd7);
    #1;
    chk("lb_bubble_regwrite", 32'(RegWrite_WB), 32'd0);
    access(2, 32'h80FF_0000);
    chk("lb_stall_cycles", stall_cnt, 32'd3);
    chk("lb_req", 32'(s_req), 32'd1);
    chk("lb_addr", s_addr, 32'h100);
    chk("lb_be", 32'(s_be), 32'hF);
    chk("lb_we", 32'(s_we), 32'd0);
    chk("lb_data", data_out, 32'hFFFF_FF80);
    chk("lb_regwrite", 32'(RegWrite_WB), 32'd1);
    chk("lb_memtoreg", 32'(MemtoReg_WB), 32'd1);
    chk("lb_req_done", 32'(bus.dmem_req), 32'd0);

    // LBU, same conditions.
    nop_cycle();
    set_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 1'b1, 5'd7);
    access(2, 32'h80FF_0000);
    chk("lbu_data", data_out, 32'h0000_0080);
    chk("lbu_stall_cycles", stall_cnt, 32'd3);

    // SH at 0x202; ack in third BUSY cycle.
    nop_cycle();
    set_op(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 1'b0, 1'b0, 5'd0);
    access(3, 32'h0);
    chk("sh_addr", s_addr, 32'h200);
    chk("sh_be", 32'(s_be), 32'hC);
    chk("sh_wdata", s_wdata, 32'h1234_1234);
    chk("sh_we_first", 32'(s_we), 32'd1);
    chk("sh_we_at_ack", 32'(ack_we), 32'd1);
    chk("sh_we_done", 32'(bus.dmem_we), 32'd0);
    chk("sh_req_cycles", req_cnt, 32'd3);

    // SB at 0x001 with read+write both high: treated as a store.
    nop_cycle();
    set_op(1'b1, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 1'b0, 1'b0, 5'd0);
    access(1, 32'h0);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(s_we), 32'd1);
    chk("sb_stall_cycles", stall_cnt, 32'd2);

    // LW at 0x101: misaligned, no request.
    nop_cycle();
    set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 1'b1, 5'd9);
    access(1, 32'h1111_1111);
    chk("mis_stall_cycles", stall_cnt, 32'd1);
    chk("mis_req_cycles", req_cnt, 32'd0);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_regwrite", 32'(RegWrite_WB), 32'd0);
    nop_cycle();
    #1;
    chk("mis_err_pulse", 32'(misalign_err), 32'd0);

    // LW at 0x400 with no ack: timeout after 4 BUSY cycles.
    set_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 1'b1, 5'd10);
    access(0, 32'h0);
    chk("to_stall_cycles", stall_cnt, 32'd5);
    chk("to_req_cycles", req_cnt, 32'd4);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_regwrite", 32'(RegWrite_WB), 32'd0);
    chk("to_req_done", 32'(bus.dmem_req), 32'd0);
    nop_cycle();
    #1;
    chk("to_err_pulse", 32'(bus_err), 32'd0);

    // LH at 0x102, ack exactly in the timeout cycle: ack wins.
    set_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 1'b1, 5'd11);
    access(4, 32'h8001_7FFF);
    chk("race_bus_err", 32'(bus_err), 32'd0);
    chk("race_data", data_out, 32'hFFFF_8001);
    chk("race_regwrite", 32'(RegWrite_WB), 32'd1);

    // Reset during BUSY, then a stray ack.
    nop_cycle();
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 1'b1, 5'd12);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstb_req_busy", 32'(bus.dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstb_req", 32'(bus.dmem_req), 32'd0);
    chk("rstb_stall", 32'(stall_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    chk("stray_stall", 32'(stall_out), 32'd0);
    chk("stray_req", 32'(bus.dmem_req), 32'd0);
    chk("stray_data", data_out, 32'h0);
    chk("stray_bus_err", 32'(bus_err), 32'd0);

    // LHU at 0x106 after reset: best-case latency.
    set_op(1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 1'b1, 1'b1, 5'd13);
    access(1, 32'hBEEF_0000);
    chk("lhu_stall_cycles", stall_cnt, 32'd2);
    chk("lhu_data", data_out, 32'h0000_BEEF);
    chk("lhu_rd", 32'(rd_out), 32'd13);
    nop_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
